// File: rtl/line_raster_engine.sv
// Bresenham line stepper: takes one clipped segment at a time and emits one pixel write per
// accepted handshake, pulsing line_done on the last accepted pixel.
module line_raster_engine #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_start,
  input  logic           vld,
  input  logic [X_W-1:0] x0_in,
  input  logic [X_W-1:0] x1_in,
  input  logic [Y_W-1:0] y0_in,
  input  logic [Y_W-1:0] y1_in,
  input  logic [2:0]     line_color,
  output logic           line_ready,
  output logic           px_vld,
  output logic [9:0]     px_x,
  output logic [8:0]     px_y,
  output logic [2:0]     px_color,
  input  logic           px_rdy,
  output logic           line_done,
  output logic           busy
);

  // Error term needs two bits of headroom over the widest coordinate.
  localparam int unsigned EW = ((X_W > Y_W) ? X_W : Y_W) + 2;

  typedef enum logic [1:0] {StIdle, StSetup, StDraw} state_e;

  state_e                state_q, state_d;
  logic [X_W-1:0]        x_q, x_d, x1_q, x1_d, dx_q, dx_d;
  logic [Y_W-1:0]        y_q, y_d, y1_q, y1_d;
  logic [2:0]            color_q, color_d;
  logic signed [Y_W:0]   dy_q, dy_d;
  logic                  sx_q, sx_d, sy_q, sy_d;
  logic signed [EW-1:0]  err_q, err_d;

  logic [X_W-1:0]        adx;
  logic [Y_W-1:0]        ady;
  logic signed [Y_W:0]   dy_new;
  logic signed [EW:0]    adx_ext, dyn_ext, dx_ext, dy_ext, err_ext, e2;
  logic signed [EW:0]    setup_sum, draw_sum, dy_add, dx_add;
  logic                  x_step, y_step, at_end, hs;

  // Setup arithmetic: x_q/y_q already hold the start point when SETUP runs.
  assign adx     = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
  assign ady     = (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q);
  assign dy_new  = -$signed({1'b0, ady});
  assign adx_ext = {{(EW + 1 - X_W){1'b0}}, adx};
  assign dyn_ext = {{(EW - Y_W){dy_new[Y_W]}}, dy_new};
  assign setup_sum = adx_ext + dyn_ext;

  // Step decision from the old error term; both axis updates may fire together.
  assign dx_ext  = {{(EW + 1 - X_W){1'b0}}, dx_q};
  assign dy_ext  = {{(EW - Y_W){dy_q[Y_W]}}, dy_q};
  assign err_ext = {err_q[EW-1], err_q};
  assign e2      = {err_q, 1'b0};
  assign x_step  = (e2 >= dy_ext);
  assign y_step  = (e2 <= dx_ext);
  assign dy_add  = x_step ? dy_ext : '0;
  assign dx_add  = y_step ? dx_ext : '0;
  assign draw_sum = err_ext + dy_add + dx_add;

  assign at_end = (x_q == x1_q) && (y_q == y1_q);
  assign hs     = (state_q == StDraw) && px_rdy;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    if (frame_start) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (vld) begin
            x_d     = x0_in;
            y_d     = y0_in;
            x1_d    = x1_in;
            y1_d    = y1_in;
            color_d = line_color;
            state_d = StSetup;
          end
        end
        StSetup: begin
          dx_d    = adx;
          dy_d    = dy_new;
          sx_d    = (x_q < x1_q);
          sy_d    = (y_q < y1_q);
          err_d   = setup_sum[EW-1:0];
          state_d = StDraw;
        end
        StDraw: begin
          if (px_rdy) begin
            if (at_end) begin
              state_d = StIdle;
            end else begin
              if (x_step) x_d = sx_q ? (x_q + 1'b1) : (x_q - 1'b1);
              if (y_step) y_d = sy_q ? (y_q + 1'b1) : (y_q - 1'b1);
              err_d = draw_sum[EW-1:0];
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

  assign line_ready = (state_q == StIdle);
  assign busy       = !line_ready;
  assign px_vld     = (state_q == StDraw);
  assign px_x       = 10'(x_q);
  assign px_y       = y_q[8:0];
  assign px_color   = color_q;
  assign line_done  = hs && at_end && !frame_start;

endmodule
